scalar_reg_bank_mw: RTL

//  Multi-warp scalar register file: one bank of NUM_REGS x DATA_WIDTH registers per warp.

---
 rtl/scalar_reg_bank_mw_pkg.sv | 44 ++++
 rtl/scalar_reg_bank_mw_chk.sv | 21 ++
 rtl/scalar_rf_scoreboard.sv | 53 +++++
 rtl/scalar_reg_bank_mw.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/scalar_reg_bank_mw_pkg.sv
// Shared types and constants for the multi-warp scalar register file.
// DATA_WIDTH is taken from the `DATA_WIDTH macro (32 when not supplied).
// Contents: data_t, warp_id_t, reg_addr_t, reg_input_mux_t,
// instruction_memory_address_t, ZERO_REG, EXEC_MASK_REG, src_is_valid().
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package scalar_reg_bank_mw_pkg;

  localparam int DATA_WIDTH      = `DATA_WIDTH;
  localparam int DEF_NUM_WARPS   = 4;
  localparam int DEF_NUM_REGS    = 32;
  localparam int DEF_WARP_ID_W   = $clog2((DEF_NUM_WARPS > 2) ? DEF_NUM_WARPS : 2);
  localparam int DEF_REG_ADDR_W  = $clog2(DEF_NUM_REGS);
  localparam int PC_WIDTH        = 16;

  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [DEF_WARP_ID_W-1:0]  warp_id_t;
  typedef logic [DEF_REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [PC_WIDTH-1:0]       instruction_memory_address_t;

  typedef enum logic [2:0] {
    ALU_OUT          = 3'd0,
    LSU_OUT          = 3'd1,
    IMMEDIATE        = 3'd2,
    PC_PLUS_1        = 3'd3,
    VECTOR_TO_SCALAR = 3'd4
  } reg_input_mux_t;

  // Register 0 reads as zero; the last register holds the warp's execution mask.
  localparam reg_addr_t ZERO_REG      = reg_addr_t'(32'd0);
  localparam reg_addr_t EXEC_MASK_REG = reg_addr_t'(DEF_NUM_REGS - 1);

  function automatic logic src_is_valid(input reg_input_mux_t s);
    logic ok;
    case (s)
      ALU_OUT, LSU_OUT, IMMEDIATE, PC_PLUS_1, VECTOR_TO_SCALAR: ok = 1'b1;
      default:                                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/scalar_reg_bank_mw_chk.sv
// Simulation checker for scalar_reg_bank_mw: flags write-backs whose
// wb_src is not one of the defined sources (such writes are dropped).
// Ports: clk, reset, wb_valid, wb_src.
module scalar_reg_bank_mw_chk
  import scalar_reg_bank_mw_pkg::*;
(
  input logic           clk,
  input logic           reset,
  input logic           wb_valid,
  input reg_input_mux_t wb_src
);

  // Undefined write-back source select
  always @(posedge clk) begin
    if (!reset && wb_valid) begin
      assert (src_is_valid(wb_src))
        else $error("scalar_reg_bank_mw: undefined wb_src %0d, write dropped", wb_src);
    end
  end

endmodule

// File: rtl/scalar_rf_scoreboard.sv
// Pending-write scoreboard: one bit per (warp, register).
// Ports: clk/reset; set_en/set_warp/set_addr marks a register pending;
// clr_en/clr_warp/clr_addr clears it (set wins on a same-bit collision);
// lk_warp + lk_addr[2:0] give a combinational 3-index lookup on lk_pend[2:0].
// Callers gate set/clear/lookup for out-of-range warp ids.
module scalar_rf_scoreboard
  import scalar_reg_bank_mw_pkg::*;
#(
  parameter int NUM_WARPS  = DEF_NUM_WARPS,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int WARP_ID_W  = DEF_WARP_ID_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       set_en,
  input  logic [WARP_ID_W-1:0]       set_warp,
  input  logic [REG_ADDR_W-1:0]      set_addr,
  input  logic                       clr_en,
  input  logic [WARP_ID_W-1:0]       clr_warp,
  input  logic [REG_ADDR_W-1:0]      clr_addr,
  input  logic [WARP_ID_W-1:0]       lk_warp,
  input  logic [2:0][REG_ADDR_W-1:0] lk_addr,
  output logic [2:0]                 lk_pend
);

  logic [NUM_REGS-1:0] pend_r [NUM_WARPS];

  // Pending bit update; the set is applied after the clear so it wins
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pend_r[w] <= {NUM_REGS{1'b0}};
      end
    end else begin
      if (clr_en) begin
        pend_r[clr_warp][clr_addr] <= 1'b0;
      end
      if (set_en) begin
        pend_r[set_warp][set_addr] <= 1'b1;
      end
    end
  end

  // Three-way lookup of the current pending state
  always_comb begin
    lk_pend = 3'b000;
    for (int i = 0; i < 3; i++) begin
      lk_pend[i] = pend_r[lk_warp][lk_addr[i]];
    end
  end

endmodule

// File: rtl/scalar_reg_bank_mw.sv
// Multi-warp scalar register file with registered 2-read/1-write access and
// a pending scoreboard for long-latency (LSU) writes.
// Ports: clk, reset (sync, active-high); read: rd_valid, rd_warp_id, rs1_addr,
// rs2_addr, rd_addr_chk -> rs1_data, rs2_data, rd_resp_valid, hazard (1 cycle);
// pend: pend_valid, pend_warp_id, pend_rd_addr; write-back: wb_valid,
// wb_warp_id, wb_rd_addr, wb_src, wb_alu, wb_lsu, wb_imm, wb_pc, wb_v2s;
// exec_mask: every warp's last register, warp w at [w*DATA_WIDTH +: DATA_WIDTH].
// Optional feature macro SCALAR_RF_BYPASS_EN: same-cycle write-to-read bypass
// of data and of the scoreboard clear.
module scalar_reg_bank_mw
  import scalar_reg_bank_mw_pkg::*;
#(
  parameter int NUM_WARPS  = DEF_NUM_WARPS,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int WARP_ID_W  = $clog2((NUM_WARPS > 2) ? NUM_WARPS : 2),
  parameter int REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rd_valid,
  input  logic [WARP_ID_W-1:0]            rd_warp_id,
  input  logic [REG_ADDR_W-1:0]           rs1_addr,
  input  logic [REG_ADDR_W-1:0]           rs2_addr,
  input  logic [REG_ADDR_W-1:0]           rd_addr_chk,
  output logic [DATA_WIDTH-1:0]           rs1_data,
  output logic [DATA_WIDTH-1:0]           rs2_data,
  output logic                            rd_resp_valid,
  output logic                            hazard,
  input  logic                            pend_valid,
  input  logic [WARP_ID_W-1:0]            pend_warp_id,
  input  logic [REG_ADDR_W-1:0]           pend_rd_addr,
  input  logic                            wb_valid,
  input  logic [WARP_ID_W-1:0]            wb_warp_id,
  input  logic [REG_ADDR_W-1:0]           wb_rd_addr,
  input  reg_input_mux_t                  wb_src,
  input  logic [DATA_WIDTH-1:0]           wb_alu,
  input  logic [DATA_WIDTH-1:0]           wb_lsu,
  input  logic [DATA_WIDTH-1:0]           wb_imm,
  input  instruction_memory_address_t     wb_pc,
  input  logic [DATA_WIDTH-1:0]           wb_v2s,
  output logic [NUM_WARPS*DATA_WIDTH-1:0] exec_mask
);

  // Warp ids can encode more slots than there are warps; this mask marks the real ones.
  localparam int                      WARP_SLOTS = 1 << WARP_ID_W;
  localparam logic [WARP_SLOTS-1:0]   WARP_OK    = {WARP_SLOTS{1'b1}} >> (WARP_SLOTS - NUM_WARPS);
  localparam logic [REG_ADDR_W-1:0]   ZERO_IDX   = REG_ADDR_W'(ZERO_REG);
  localparam logic [REG_ADDR_W-1:0]   ONE_IDX    = REG_ADDR_W'(32'd1);
  localparam logic [REG_ADDR_W-1:0]   EXEC_IDX   = REG_ADDR_W'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0]       regs_r [NUM_WARPS][NUM_REGS];
  logic [DATA_WIDTH-1:0]       wb_data_s;
  instruction_memory_address_t pc_plus_1_s;
  logic                        wb_src_ok_s;
  logic                        wb_en_s;
  logic                        lsu_clr_s;
  logic                        pend_set_s;
  logic                        rd_ok_s;
  logic [2:0][REG_ADDR_W-1:0]  lk_addr_s;
  logic [2:0]                  lk_pend_s;
  logic [2:0]                  clr_hit_s;
  logic [1:0][DATA_WIDTH-1:0]  rs_nxt_s;
  logic                        hazard_nxt_s;

  // Write-back value selection
  always_comb begin
    pc_plus_1_s = wb_pc + PC_WIDTH'(1'b1);
    wb_src_ok_s = 1'b1;
    case (wb_src)
      ALU_OUT:          wb_data_s = wb_alu;
      LSU_OUT:          wb_data_s = wb_lsu;
      IMMEDIATE:        wb_data_s = wb_imm;
      PC_PLUS_1:        wb_data_s = DATA_WIDTH'(pc_plus_1_s);
      VECTOR_TO_SCALAR: wb_data_s = wb_v2s;
      default: begin
        wb_data_s   = {DATA_WIDTH{1'b0}};
        wb_src_ok_s = 1'b0;
      end
    endcase
  end

  assign wb_en_s    = wb_valid && WARP_OK[wb_warp_id] && wb_src_ok_s && (wb_rd_addr != ZERO_IDX);
  assign lsu_clr_s  = wb_valid && WARP_OK[wb_warp_id] && (wb_src == LSU_OUT);
  assign pend_set_s = pend_valid && WARP_OK[pend_warp_id] && (pend_rd_addr != ZERO_IDX);
  assign rd_ok_s    = WARP_OK[rd_warp_id];
  assign lk_addr_s  = {rd_addr_chk, rs2_addr, rs1_addr};

  scalar_rf_scoreboard #(
    .NUM_WARPS  (NUM_WARPS),
    .NUM_REGS   (NUM_REGS),
    .WARP_ID_W  (WARP_ID_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (pend_set_s),
    .set_warp (pend_warp_id),
    .set_addr (pend_rd_addr),
    .clr_en   (lsu_clr_s),
    .clr_warp (wb_warp_id),
    .clr_addr (wb_rd_addr),
    .lk_warp  (rd_warp_id),
    .lk_addr  (lk_addr_s),
    .lk_pend  (lk_pend_s)
  );

  scalar_reg_bank_mw_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_src   (wb_src)
  );

  // Next read data for rs1/rs2; register 0 and unknown warps read as zero
  always_comb begin
    rs_nxt_s = '0;
    for (int i = 0; i < 2; i++) begin
      if (!rd_ok_s || (lk_addr_s[i] == ZERO_IDX)) begin
        rs_nxt_s[i] = {DATA_WIDTH{1'b0}};
`ifdef SCALAR_RF_BYPASS_EN
      end else if (wb_en_s && (wb_warp_id == rd_warp_id) && (wb_rd_addr == lk_addr_s[i])) begin
        rs_nxt_s[i] = wb_data_s;
`endif
      end else begin
        rs_nxt_s[i] = regs_r[rd_warp_id][lk_addr_s[i]];
      end
    end
  end

  // Hazard from the pre-update scoreboard, optionally ignoring a bit this cycle's LSU write clears
  always_comb begin
    clr_hit_s = 3'b000;
`ifdef SCALAR_RF_BYPASS_EN
    for (int i = 0; i < 3; i++) begin
      clr_hit_s[i] = lsu_clr_s && (wb_warp_id == rd_warp_id) && (wb_rd_addr == lk_addr_s[i]);
    end
`endif
    if (rd_ok_s) begin
      hazard_nxt_s = |(lk_pend_s & ~clr_hit_s);
    end else begin
      hazard_nxt_s = 1'b0;
    end
  end

  // Register storage: reg 1 and the exec-mask register reset to all ones
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if ((REG_ADDR_W'(r) == ONE_IDX) || (REG_ADDR_W'(r) == EXEC_IDX)) begin
            regs_r[w][r] <= {DATA_WIDTH{1'b1}};
          end else begin
            regs_r[w][r] <= {DATA_WIDTH{1'b0}};
          end
        end
      end
    end else if (wb_en_s) begin
      regs_r[wb_warp_id][wb_rd_addr] <= wb_data_s;
    end
  end

  // Registered read response; data and hazard hold while no read is requested
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_data      <= {DATA_WIDTH{1'b0}};
      rs2_data      <= {DATA_WIDTH{1'b0}};
      rd_resp_valid <= 1'b0;
      hazard        <= 1'b0;
    end else begin
      rd_resp_valid <= rd_valid;
      if (rd_valid) begin
        rs1_data <= rs_nxt_s[0];
        rs2_data <= rs_nxt_s[1];
        hazard   <= hazard_nxt_s;
      end
    end
  end

  // Execution masks straight from register state
  always_comb begin
    exec_mask = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      exec_mask[w*DATA_WIDTH +: DATA_WIDTH] = regs_r[w][EXEC_IDX];
    end
  end

endmodule
